// File: rtl/cordic_result_buffer_pkg.sv
// Shared constants and result type for the CORDIC result capture stage.
package cordic_result_buffer_pkg;

  localparam int CRB_DATA_WIDTH   = 16;
  // Must track the register depth of the CORDIC pipeline feeding this buffer.
  localparam int CRB_PIPE_LATENCY = 9;
  localparam int CRB_FIFO_DEPTH   = 8;

  typedef struct packed {
    logic [CRB_DATA_WIDTH-1:0] degree;
    logic [CRB_DATA_WIDTH-1:0] x;
    logic [CRB_DATA_WIDTH-1:0] y;
  } cordic_result_t;

endpackage

// File: rtl/cordic_result_buffer_if.sv
// Valid/ready result stream from the capture FIFO to its consumer.
interface cordic_result_if
  import cordic_result_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = CRB_DATA_WIDTH
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_degree;
  logic [DATA_WIDTH-1:0] m_x;
  logic [DATA_WIDTH-1:0] m_y;

  modport master (output m_valid, m_degree, m_x, m_y, input m_ready);
  modport slave  (input m_valid, m_degree, m_x, m_y, output m_ready);
endinterface

// File: rtl/cordic_result_buffer_valid_delay.sv
// Issue-strobe delay line matched to the CORDIC pipeline latency.
module cordic_valid_delay #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH:1] vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= din;
      for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout = vld_pipe[DEPTH];

endmodule

// File: rtl/cordic_result_buffer.sv
// Capture FIFO for CORDIC results; drops and flags results arriving while full.
// Optional CORDIC_RESULT_OVF_CNT_EN adds a saturating drop counter ovf_count.
module cordic_result_buffer
  import cordic_result_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = CRB_DATA_WIDTH,
  parameter int PIPE_LATENCY = CRB_PIPE_LATENCY,
  parameter int FIFO_DEPTH   = CRB_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic [DATA_WIDTH-1:0]         degree_out,
  input  logic [DATA_WIDTH-1:0]         x_out,
  input  logic [DATA_WIDTH-1:0]         y_out,
  cordic_result_if.master               m,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
`ifdef CORDIC_RESULT_OVF_CNT_EN
  output logic [15:0]                   ovf_count,
`endif
  input  logic                          clear_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] degree;
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_nxt;
  logic            valid_q, tap, full, pop, push, drop;

  cordic_valid_delay #(.DEPTH(PIPE_LATENCY)) u_dly (
    .clk  (clk),
    .reset(reset),
    .din  (issue_valid),
    .dout (tap)
  );

  assign full = (level == LW'(FIFO_DEPTH));
  assign pop  = valid_q && m.m_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push = tap && (!full || pop);
  assign drop = tap && full && !pop;

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + LW'(1);
    else if (pop && !push) level_nxt = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {degree_out, x_out, y_out};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level   <= level_nxt;
      valid_q <= (level_nxt != '0);
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

`ifdef CORDIC_RESULT_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                          ovf_count <= '0;
    else if (clear_ovf)                 ovf_count <= {15'd0, drop};
    else if (drop && ovf_count != '1)   ovf_count <= ovf_count + 16'd1;
  end
`endif

  // Head read is combinational; gating keeps the bus quiet while empty.
  assign head       = valid_q ? mem[rd_ptr] : '0;
  assign m.m_valid  = valid_q;
  assign m.m_degree = head.degree;
  assign m.m_x      = head.x;
  assign m.m_y      = head.y;

endmodule

// File: tb/tb_cordic_result_buffer.sv
// Randomized self-checking bench for cordic_result_buffer against a queue model.
module tb_cordic_result_buffer;
  import cordic_result_buffer_pkg::*;

  localparam int DW = 16;
  localparam int L  = 9;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          issue_valid = 1'b0;
  logic          clear_ovf = 1'b0;
  logic [DW-1:0] degree_out = '0, x_out = '0, y_out = '0;
  logic [3:0]    level;
  logic          overflow;
`ifdef CORDIC_RESULT_OVF_CNT_EN
  logic [15:0]   ovf_count;
`endif

  cordic_result_if #(.DATA_WIDTH(DW)) mif ();

  cordic_result_buffer #(.DATA_WIDTH(DW), .PIPE_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .degree_out (degree_out),
    .x_out      (x_out),
    .y_out      (y_out),
    .m          (mif),
    .level      (level),
    .overflow   (overflow),
`ifdef CORDIC_RESULT_OVF_CNT_EN
    .ovf_count  (ovf_count),
`endif
    .clear_ovf  (clear_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: issue cycle numbers in flight, stored results, flags.
  int             cyc = 0;
  int             issue_q[$];
  cordic_result_t fifo_q[$];
  bit             m_ovf = 0;
  int             m_cnt = 0;

  bit             e_valid, e_ovf;
  int             e_level, e_cnt;
  cordic_result_t e_head;
  logic [53:0]    act, exp;
  int             n_chk = 0, n_fail = 0;

  // Drive one cycle, snapshot the model's expected outputs, advance the model.
  task automatic cycle(input bit iv, input bit rdy, input bit clr, input bit rst);
    bit tap, pop, drop;
    cordic_result_t r;
    @(negedge clk);
    reset = rst; issue_valid = iv; mif.m_ready = rdy; clear_ovf = clr;
    degree_out = 16'(cyc * 16);
    x_out = 16'($urandom);
    y_out = 16'($urandom);
    #1;
    e_valid = (fifo_q.size() != 0);
    e_level = fifo_q.size();
    e_ovf   = m_ovf;
    e_cnt   = m_cnt;
    e_head  = e_valid ? fifo_q[0] : '0;
    if (rst) begin
      issue_q.delete(); fifo_q.delete(); m_ovf = 0; m_cnt = 0;
    end else begin
      tap = (issue_q.size() != 0) && (issue_q[0] == cyc - L);
      if (tap) void'(issue_q.pop_front());
      pop = e_valid && rdy;
      if (pop) void'(fifo_q.pop_front());
      drop = 0;
      if (tap) begin
        if (fifo_q.size() < D) begin
          r.degree = degree_out; r.x = x_out; r.y = y_out;
          fifo_q.push_back(r);
        end else drop = 1;
      end
      if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
      if (clr) m_cnt = drop ? 1 : 0;
      else if (drop && m_cnt < 65535) m_cnt++;
      if (iv) issue_q.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, k < 3);
      if (k >= 1) begin
        n_chk++;
        act = {mif.m_valid, level, overflow, mif.m_degree, mif.m_x, mif.m_y};
        if (act !== 54'd0) begin
          n_fail++; $display("FAIL reset_state: got %h want 0", act);
        end
      end
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] want_deg = '0, want_x = '0, want_y = '0;
    for (int k = 0; k < 14; k++) begin
      cycle(k == 0, 1, 0, 0);
      if (k == 9) begin want_deg = degree_out; want_x = x_out; want_y = y_out; end
      n_chk++;
      if (mif.m_valid !== (k == 10)) begin
        n_fail++; $display("FAIL single_valid k=%0d: got %b want %b", k, mif.m_valid, (k == 10));
      end
      if (k == 10) begin
        n_chk++;
        if ({mif.m_degree, mif.m_x, mif.m_y} !== {want_deg, want_x, want_y}) begin
          n_fail++;
          $display("FAIL single_data: got %h want %h", {mif.m_degree, mif.m_x, mif.m_y},
                   {want_deg, want_x, want_y});
        end
      end
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] prev = '0;
    for (int k = 0; k < 42; k++) begin
      cycle(k < 30, 1, 0, 0);
      act = {mif.m_valid, level, overflow, mif.m_degree, mif.m_x, mif.m_y};
      exp = {e_valid, 4'(e_level), e_ovf, e_head};
      n_chk++;
      if (act !== exp) begin n_fail++; $display("FAIL stream_model k=%0d: got %h want %h", k, act, exp); end
      if (k >= 10 && k < 30) begin
        n_chk++;
        if ({mif.m_valid, level, overflow} !== {1'b1, 4'd1, 1'b0}) begin
          n_fail++; $display("FAIL stream_level k=%0d: got v=%b l=%0d o=%b want v=1 l=1 o=0",
                             k, mif.m_valid, level, overflow);
        end
        if (k >= 11) begin
          n_chk++;
          if (mif.m_degree - prev !== 16'h0010) begin
            n_fail++; $display("FAIL stream_step k=%0d: got %h want 0010", k, mif.m_degree - prev);
          end
        end
        prev = mif.m_degree;
      end
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 12 + L + 2; k++) begin
      cycle(k < 12, 0, 0, 0);
      act = {mif.m_valid, level, overflow, mif.m_degree, mif.m_x, mif.m_y};
      exp = {e_valid, 4'(e_level), e_ovf, e_head};
      n_chk++;
      if (act !== exp) begin n_fail++; $display("FAIL fill_model k=%0d: got %h want %h", k, act, exp); end
    end
    n_chk++;
    if ({level, overflow} !== {4'd8, 1'b1}) begin
      n_fail++; $display("FAIL fill_end: got l=%0d o=%b want l=8 o=1", level, overflow);
    end
`ifdef CORDIC_RESULT_OVF_CNT_EN
    n_chk++;
    if (ovf_count !== 16'd4) begin n_fail++; $display("FAIL fill_cnt: got %0d want 4", ovf_count); end
`endif
  endtask

  task automatic test_full_pop();
    for (int k = 0; k <= L + 1; k++) begin
      cycle(k == 0, k == L, k == 0, 0);
      act = {mif.m_valid, level, overflow, mif.m_degree, mif.m_x, mif.m_y};
      exp = {e_valid, 4'(e_level), e_ovf, e_head};
      n_chk++;
      if (act !== exp) begin n_fail++; $display("FAIL fullpop_model k=%0d: got %h want %h", k, act, exp); end
    end
    n_chk++;
    if ({level, overflow} !== {4'd8, 1'b0}) begin
      n_fail++; $display("FAIL fullpop_end: got l=%0d o=%b want l=8 o=0", level, overflow);
    end
  endtask

  task automatic test_clear_drop();
    for (int k = 0; k <= L + 1; k++) begin
      cycle(k == 0, 0, k == L, 0);
      act = {mif.m_valid, level, overflow, mif.m_degree, mif.m_x, mif.m_y};
      exp = {e_valid, 4'(e_level), e_ovf, e_head};
      n_chk++;
      if (act !== exp) begin n_fail++; $display("FAIL clrdrop_model k=%0d: got %h want %h", k, act, exp); end
    end
    n_chk++;
    if ({level, overflow} !== {4'd8, 1'b1}) begin
      n_fail++; $display("FAIL clrdrop_end: got l=%0d o=%b want l=8 o=1", level, overflow);
    end
`ifdef CORDIC_RESULT_OVF_CNT_EN
    n_chk++;
    if (ovf_count !== 16'd1) begin n_fail++; $display("FAIL clrdrop_cnt: got %0d want 1", ovf_count); end
`endif
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 10; k++) cycle(0, 1, 1, 0);
    for (int k = 0; k < 22; k++) begin
      cycle(k == 0, 1, 0, k == 5);
      if (k >= 6) begin
        act = {mif.m_valid, level, overflow, mif.m_degree, mif.m_x, mif.m_y};
        n_chk++;
        if (act !== 54'd0) begin n_fail++; $display("FAIL inflight k=%0d: got %h want 0", k, act); end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 15) == 0, 0);
      act = {mif.m_valid, level, overflow, mif.m_degree, mif.m_x, mif.m_y};
      exp = {e_valid, 4'(e_level), e_ovf, e_head};
      n_chk++;
      if (act !== exp) begin n_fail++; $display("FAIL random_model k=%0d: got %h want %h", k, act, exp); end
`ifdef CORDIC_RESULT_OVF_CNT_EN
      n_chk++;
      if (ovf_count !== 16'(e_cnt)) begin
        n_fail++; $display("FAIL random_cnt k=%0d: got %0d want %0d", k, ovf_count, e_cnt);
      end
`endif
    end
  endtask

  initial begin
    mif.m_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_fill();
    test_full_pop();
    test_clear_drop();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
